// File: rtl/hex_fw_loader_pkg.sv
// ---------------------------------------------------------------------------
// hex_fw_loader_pkg
// Shared types and constants for the ASCII hex firmware loader.
//   loader_state_t : loader FSM states
//   loader_err_t   : error codes reported on error_code
//   CHAR_*         : ASCII codes the character decoder recognises
// ---------------------------------------------------------------------------
package hex_fw_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA  = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_ILLEGAL   = 2'd1,
        ERR_PARTIAL   = 2'd2,
        ERR_ADDR_LONG = 2'd3
    } loader_err_t;

    localparam logic [7:0] CHAR_EOT   = 8'h04;
    localparam logic [7:0] CHAR_AT    = 8'h40;
    localparam logic [7:0] CHAR_COLON = 8'h3A;
    localparam logic [7:0] CHAR_SP    = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_TAB   = 8'h09;

endpackage

// File: rtl/hex_fw_loader_char_decode.sv
// ---------------------------------------------------------------------------
// hex_char_decode
// Purely combinational classifier for one ASCII character.
//   char_in : ASCII character
//   is_hex  : character is 0-9, A-F or a-f
//   nib     : nibble value of a hex digit (0 otherwise)
//   is_sep  : space, tab, CR, LF or ':'
//   is_at   : '@' (address record)
//   is_eot  : end-of-transmission (8'h04)
// ---------------------------------------------------------------------------
module hex_char_decode
    import hex_fw_loader_pkg::*;
(
    input  logic [7:0] char_in,
    output logic       is_hex,
    output logic [3:0] nib,
    output logic       is_sep,
    output logic       is_at,
    output logic       is_eot
);

    logic [7:0] offset;

    // Hex digits map to their nibble by subtracting the start of their
    // ASCII range; letters subtract 10 less so 'A'/'a' land on 4'hA.
    always_comb begin
        is_hex = 1'b0;
        offset = 8'h00;
        if (char_in >= 8'h30 && char_in <= 8'h39) begin
            is_hex = 1'b1;
            offset = char_in - 8'h30;
        end else if (char_in >= 8'h41 && char_in <= 8'h46) begin
            is_hex = 1'b1;
            offset = char_in - 8'h37;
        end else if (char_in >= 8'h61 && char_in <= 8'h66) begin
            is_hex = 1'b1;
            offset = char_in - 8'h57;
        end
        nib = offset[3:0];
    end

    // ':' is accepted as a plain separator so Intel-style line starts pass.
    assign is_sep = (char_in == CHAR_SP)  || (char_in == CHAR_TAB) ||
                    (char_in == CHAR_CR)  || (char_in == CHAR_LF)  ||
                    (char_in == CHAR_COLON);
    assign is_at  = (char_in == CHAR_AT);
    assign is_eot = (char_in == CHAR_EOT);

endmodule

// File: rtl/hex_fw_loader.sv
// ---------------------------------------------------------------------------
// hex_fw_loader
// Decodes an ASCII hex character stream into memory writes, with '@addr'
// relocation records, EOT termination and error reporting. The CPU is held
// off (cpu_run=0) until a load completes cleanly.
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : one-cycle pulse to begin a load (ignored while busy)
//   char_valid, char_in   : incoming character; char_ready marks acceptance
//   mem_we/addr/din       : registered memory write port
//   busy, done, error     : load status; done/error held until next start
//   error_code            : 0 none, 1 illegal char, 2 partial word, 3 addr too long
//   word_count            : words written since start (saturating)
//   cpu_run               : mirrors done
// ---------------------------------------------------------------------------
module hex_fw_loader
    import hex_fw_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  char_valid,
    input  logic [7:0]            char_in,
    output logic                  char_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            error_code,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  cpu_run
);

    localparam int NIBS   = DATA_WIDTH / 4;
    localparam int NIB_W  = $clog2(NIBS + 1);
    localparam int ADIGS  = ADDR_WIDTH / 4;
    localparam int ADIG_W = $clog2(ADIGS + 1);

    localparam logic [NIB_W-1:0]  LAST_NIB  = NIB_W'(NIBS - 1);
    localparam logic [ADIG_W-1:0] MAX_ADIGS = ADIG_W'(ADIGS);

    loader_state_t           state, state_n;
    loader_err_t             err, err_n;
    logic [ADDR_WIDTH-1:0]   addr, addr_n;
    logic [ADDR_WIDTH-1:0]   addr_acc, addr_acc_n;
    logic [ADIG_W-1:0]       addr_digs, addr_digs_n;
    logic [DATA_WIDTH-1:0]   word, word_n;
    logic [NIB_W-1:0]        nib_cnt, nib_cnt_n;
    logic [ADDR_WIDTH:0]     wcount, wcount_n;

    logic       is_hex, is_sep, is_at, is_eot;
    logic [3:0] nib;
    logic       take;

    hex_char_decode u_decode (
        .char_in (char_in),
        .is_hex  (is_hex),
        .nib     (nib),
        .is_sep  (is_sep),
        .is_at   (is_at),
        .is_eot  (is_eot)
    );

    // Status outputs come straight from the state register, so an
    // asynchronous reset drops mem_we and busy without waiting for a clock.
    assign char_ready = (state == ST_DATA) || (state == ST_ADDR);
    assign busy       = char_ready || (state == ST_WRITE);
    assign mem_we     = (state == ST_WRITE);
    assign done       = (state == ST_DONE);
    assign error      = (state == ST_ERROR);
    assign cpu_run    = done;
    assign error_code = err;
    assign mem_addr   = addr;
    assign mem_din    = word;
    assign word_count = wcount;
    assign take       = char_valid && char_ready;

    // State and datapath register. addr and word double as the write port,
    // so they stay stable through the whole WRITE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            err       <= ERR_NONE;
            addr      <= BASE_ADDR;
            addr_acc  <= '0;
            addr_digs <= '0;
            word      <= '0;
            nib_cnt   <= '0;
            wcount    <= '0;
        end else begin
            state     <= state_n;
            err       <= err_n;
            addr      <= addr_n;
            addr_acc  <= addr_acc_n;
            addr_digs <= addr_digs_n;
            word      <= word_n;
            nib_cnt   <= nib_cnt_n;
            wcount    <= wcount_n;
        end
    end

    // Next-state and datapath update. Characters are only acted on when
    // consumed (take); WRITE spends one cycle with char_ready low.
    always_comb begin
        state_n     = state;
        err_n       = err;
        addr_n      = addr;
        addr_acc_n  = addr_acc;
        addr_digs_n = addr_digs;
        word_n      = word;
        nib_cnt_n   = nib_cnt;
        wcount_n    = wcount;

        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_n     = ST_DATA;
                    err_n       = ERR_NONE;
                    addr_n      = BASE_ADDR;
                    addr_acc_n  = '0;
                    addr_digs_n = '0;
                    word_n      = '0;
                    nib_cnt_n   = '0;
                    wcount_n    = '0;
                end
            end

            ST_DATA: begin
                if (take) begin
                    if (is_hex) begin
                        word_n = DATA_WIDTH'({word, nib});
                        if (nib_cnt == LAST_NIB) begin
                            nib_cnt_n = '0;
                            state_n   = ST_WRITE;
                        end else begin
                            nib_cnt_n = nib_cnt + NIB_W'(1);
                        end
                    end else if (is_sep || is_at || is_eot) begin
                        if (nib_cnt != '0) begin
                            state_n = ST_ERROR;
                            err_n   = ERR_PARTIAL;
                        end else if (is_at) begin
                            addr_acc_n  = '0;
                            addr_digs_n = '0;
                            state_n     = ST_ADDR;
                        end else if (is_eot) begin
                            state_n = ST_DONE;
                        end
                    end else begin
                        state_n = ST_ERROR;
                        err_n   = ERR_ILLEGAL;
                    end
                end
            end

            ST_ADDR: begin
                if (take) begin
                    if (is_hex) begin
                        if (addr_digs == MAX_ADIGS) begin
                            state_n = ST_ERROR;
                            err_n   = ERR_ADDR_LONG;
                        end else begin
                            addr_acc_n  = ADDR_WIDTH'({addr_acc, nib});
                            addr_digs_n = addr_digs + ADIG_W'(1);
                        end
                    end else if ((is_sep || is_eot) && addr_digs != '0) begin
                        addr_n  = addr_acc;
                        state_n = is_eot ? ST_DONE : ST_DATA;
                    end else begin
                        state_n = ST_ERROR;
                        err_n   = ERR_ILLEGAL;
                    end
                end
            end

            ST_WRITE: begin
                addr_n   = addr + ADDR_WIDTH'(1);
                wcount_n = (&wcount) ? wcount : wcount + (ADDR_WIDTH+1)'(1);
                state_n  = ST_DATA;
            end

            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_hex_fw_loader.sv
// ---------------------------------------------------------------------------
// tb_hex_fw_loader
// Self-checking bench for hex_fw_loader. One 8-bit and one 16-bit instance
// share clock and reset; expected writes are queued per instance and
// compared by a monitor whenever mem_we is seen.
// ---------------------------------------------------------------------------
module tb_hex_fw_loader;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk;
    logic        reset_n;

    logic        start8, char_valid8, char_ready8, mem_we8, busy8, done8, error8, cpu_run8;
    logic [7:0]  char_in8;
    logic [15:0] mem_addr8;
    logic [7:0]  mem_din8;
    logic [1:0]  error_code8;
    logic [16:0] word_count8;

    logic        start16, char_valid16, char_ready16, mem_we16, busy16, done16, error16, cpu_run16;
    logic [7:0]  char_in16;
    logic [15:0] mem_addr16;
    logic [15:0] mem_din16;
    logic [1:0]  error_code16;
    logic [16:0] word_count16;

    int  errors = 0;
    int  checks = 0;
    wr_t q8[$];
    wr_t q16[$];

    hex_fw_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .BASE_ADDR(16'h0200)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .char_valid(char_valid8),
        .char_in(char_in8), .char_ready(char_ready8), .mem_we(mem_we8),
        .mem_addr(mem_addr8), .mem_din(mem_din8), .busy(busy8), .done(done8),
        .error(error8), .error_code(error_code8), .word_count(word_count8),
        .cpu_run(cpu_run8)
    );

    hex_fw_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .BASE_ADDR(16'h0200)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .char_valid(char_valid16),
        .char_in(char_in16), .char_ready(char_ready16), .mem_we(mem_we16),
        .mem_addr(mem_addr16), .mem_din(mem_din16), .busy(busy16), .done(done16),
        .error(error16), .error_code(error_code16), .word_count(word_count16),
        .cpu_run(cpu_run16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitors: every observed write must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && mem_we8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("[TB] FAIL write8: unexpected write %h=%h", mem_addr8, mem_din8);
            end else begin
                wr_t e;
                e = q8.pop_front();
                if (mem_addr8 !== e.addr || mem_din8 !== e.data[7:0]) begin
                    errors++;
                    $display("[TB] FAIL write8: got %h=%h expected %h=%h",
                             mem_addr8, mem_din8, e.addr, e.data[7:0]);
                end
            end
        end
        if (reset_n && mem_we16) begin
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("[TB] FAIL write16: unexpected write %h=%h", mem_addr16, mem_din16);
            end else begin
                wr_t e;
                e = q16.pop_front();
                if (mem_addr16 !== e.addr || mem_din16 !== e.data) begin
                    errors++;
                    $display("[TB] FAIL write16: got %h=%h expected %h=%h",
                             mem_addr16, mem_din16, e.addr, e.data);
                end
            end
        end
    end

    task automatic push_wr(input int sel, input logic [15:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        if (sel == 0) q8.push_back(e);
        else          q16.push_back(e);
    endtask

    // Called at a negedge; returns at a negedge with start back low.
    task automatic pulse_start(input int sel);
        if (sel == 0) start8 = 1'b1; else start16 = 1'b1;
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
    endtask

    // Streams a string (plus optional EOT) with char_valid held high, waiting
    // on char_ready for each character. Counts cycles and ready-low cycles.
    task automatic send_string(input int sel, input string s, input bit with_eot,
                               output int cycles, output int low_cycles);
        int n;
        logic [7:0] c;
        bit consumed;
        bit rdy;
        cycles = 0;
        low_cycles = 0;
        n = s.len() + (with_eot ? 1 : 0);
        for (int i = 0; i < n; i++) begin
            c = (i < s.len()) ? s[i] : 8'h04;
            if (sel == 0) begin char_in8 = c; char_valid8 = 1'b1; end
            else          begin char_in16 = c; char_valid16 = 1'b1; end
            consumed = 1'b0;
            for (int t = 0; t < 20; t++) begin
                rdy = (sel == 0) ? char_ready8 : char_ready16;
                cycles++;
                if (rdy) begin
                    @(posedge clk);
                    @(negedge clk);
                    consumed = 1'b1;
                    break;
                end
                low_cycles++;
                @(negedge clk);
            end
            if (!consumed) begin
                checks++;
                errors++;
                $display("[TB] FAIL char_accept: char %h not accepted, got ready=0 expected 1", c);
                break;
            end
        end
        char_valid8  = 1'b0;
        char_valid16 = 1'b0;
    endtask

    task automatic check_queues_empty(input string name);
        checks++;
        if (q8.size() != 0 || q16.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_pending: got %0d/%0d writes outstanding expected 0/0",
                     name, q8.size(), q16.size());
            q8.delete();
            q16.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({char_ready8, mem_we8, busy8, done8, error8, cpu_run8} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {char_ready8, mem_we8, busy8, done8, error8, cpu_run8});
        end
        checks++;
        if (error_code8 !== 2'd0 || word_count8 !== 17'd0) begin
            errors++;
            $display("[TB] FAIL reset_counts: got code=%0d count=%0d expected 0/0",
                     error_code8, word_count8);
        end
        checks++;
        if (mem_addr8 !== 16'h0200 || mem_din8 !== 8'h00 || mem_addr16 !== 16'h0200 || mem_din16 !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_port: got %h/%h %h/%h expected 0200/00 0200/0000",
                     mem_addr8, mem_din8, mem_addr16, mem_din16);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || char_ready8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got busy=%b ready=%b expected 0/0", busy8, char_ready8);
        end
    endtask

    task automatic test_basic_load();
        int cy, lo;
        pulse_start(0);
        checks++;
        if (busy8 !== 1'b1 || char_ready8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_busy: got busy=%b ready=%b expected 1/1", busy8, char_ready8);
        end
        push_wr(0, 16'h0200, 16'h00A9);
        push_wr(0, 16'h0201, 16'h0001);
        push_wr(0, 16'h0202, 16'h008D);
        send_string(0, "A9 01 8D", 1'b1, cy, lo);
        checks++;
        if (done8 !== 1'b1 || cpu_run8 !== 1'b1 || error8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done: got done=%b run=%b err=%b busy=%b expected 1/1/0/0",
                     done8, cpu_run8, error8, busy8);
        end
        checks++;
        if (word_count8 !== 17'd3) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d expected 3", word_count8);
        end
        check_queues_empty("basic");
    endtask

    task automatic test_addr_wrap();
        int cy, lo;
        pulse_start(0);
        checks++;
        if (done8 !== 1'b0 || cpu_run8 !== 1'b0 || word_count8 !== 17'd0) begin
            errors++;
            $display("[TB] FAIL restart_clear: got done=%b run=%b count=%0d expected 0/0/0",
                     done8, cpu_run8, word_count8);
        end
        push_wr(0, 16'hFFFE, 16'h0011);
        push_wr(0, 16'hFFFF, 16'h0022);
        push_wr(0, 16'h0000, 16'h0033);
        send_string(0, "@FFFE 11 22 33", 1'b1, cy, lo);
        checks++;
        if (done8 !== 1'b1 || error8 !== 1'b0 || word_count8 !== 17'd3) begin
            errors++;
            $display("[TB] FAIL wrap_done: got done=%b err=%b count=%0d expected 1/0/3",
                     done8, error8, word_count8);
        end
        check_queues_empty("wrap");
    endtask

    task automatic test_partial_word();
        int cy, lo;
        pulse_start(0);
        push_wr(0, 16'h0200, 16'h00A9);
        send_string(0, "A9 0", 1'b1, cy, lo);
        checks++;
        if (error8 !== 1'b1 || error_code8 !== 2'd2 || done8 !== 1'b0 || cpu_run8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL partial: got err=%b code=%0d done=%b run=%b expected 1/2/0/0",
                     error8, error_code8, done8, cpu_run8);
        end
        check_queues_empty("partial");
    endtask

    task automatic test_addr_too_long();
        int cy, lo;
        pulse_start(0);
        send_string(0, "@12345", 1'b0, cy, lo);
        checks++;
        if (error8 !== 1'b1 || error_code8 !== 2'd3 || char_ready8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL addr_long: got err=%b code=%0d ready=%b expected 1/3/0",
                     error8, error_code8, char_ready8);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (error_code8 !== 2'd3 || word_count8 !== 17'd0) begin
            errors++;
            $display("[TB] FAIL addr_long_hold: got code=%0d count=%0d expected 3/0",
                     error_code8, word_count8);
        end
        check_queues_empty("addr_long");
    endtask

    task automatic test_illegal_char();
        int cy, lo;
        pulse_start(0);
        push_wr(0, 16'h0200, 16'h00A9);
        send_string(0, "A9 G", 1'b0, cy, lo);
        checks++;
        if (error8 !== 1'b1 || error_code8 !== 2'd1 || word_count8 !== 17'd1) begin
            errors++;
            $display("[TB] FAIL illegal: got err=%b code=%0d count=%0d expected 1/1/1",
                     error8, error_code8, word_count8);
        end
        check_queues_empty("illegal");
    endtask

    task automatic test_width16();
        int cy, lo;
        pulse_start(1);
        push_wr(1, 16'h0200, 16'hBEEF);
        push_wr(1, 16'h0201, 16'hCAFE);
        send_string(1, "beef CAFE", 1'b1, cy, lo);
        checks++;
        if (lo !== 2 || cy !== 12) begin
            errors++;
            $display("[TB] FAIL ready_low16: got low=%0d cycles=%0d expected 2/12", lo, cy);
        end
        checks++;
        if (done16 !== 1'b1 || word_count16 !== 17'd2) begin
            errors++;
            $display("[TB] FAIL done16: got done=%b count=%0d expected 1/2", done16, word_count16);
        end
        check_queues_empty("width16");
    endtask

    task automatic test_reset_mid_load();
        int cy, lo;
        pulse_start(0);
        push_wr(0, 16'h0200, 16'h00A9);
        send_string(0, "A9 0", 1'b0, cy, lo);
        char_in8 = "1";
        char_valid8 = 1'b1;
        @(posedge clk);
        #1;
        char_valid8 = 1'b0;
        checks++;
        if (mem_we8 !== 1'b1 || mem_addr8 !== 16'h0201 || mem_din8 !== 8'h01) begin
            errors++;
            $display("[TB] FAIL pre_reset_write: got we=%b %h=%h expected 1 0201=01",
                     mem_we8, mem_addr8, mem_din8);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_we8, busy8, char_ready8, done8, error8, cpu_run8} !== 6'b0 ||
            error_code8 !== 2'd0 || word_count8 !== 17'd0 ||
            mem_addr8 !== 16'h0200 || mem_din8 !== 8'h00) begin
            errors++;
            $display("[TB] FAIL async_reset: got flags=%b code=%0d count=%0d port=%h/%h expected 000000/0/0/0200/00",
                     {mem_we8, busy8, char_ready8, done8, error8, cpu_run8},
                     error_code8, word_count8, mem_addr8, mem_din8);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        pulse_start(0);
        checks++;
        if (word_count8 !== 17'd0 || mem_addr8 !== 16'h0200 || busy8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reload: got count=%0d addr=%h busy=%b expected 0/0200/1",
                     word_count8, mem_addr8, busy8);
        end
        push_wr(0, 16'h0200, 16'h0055);
        send_string(0, "55", 1'b1, cy, lo);
        checks++;
        if (done8 !== 1'b1 || word_count8 !== 17'd1) begin
            errors++;
            $display("[TB] FAIL reload_done: got done=%b count=%0d expected 1/1", done8, word_count8);
        end
        check_queues_empty("reset_mid");
    endtask

    initial begin
        reset_n      = 1'b0;
        start8       = 1'b0;
        start16      = 1'b0;
        char_valid8  = 1'b0;
        char_valid16 = 1'b0;
        char_in8     = 8'h00;
        char_in16    = 8'h00;
        @(negedge clk);
        test_reset();
        test_basic_load();
        test_addr_wrap();
        test_partial_word();
        test_addr_too_long();
        test_illegal_char();
        test_width16();
        test_reset_mid_load();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/hex_fw_loader.md
# hex_fw_loader

Synthesizable firmware loader that accepts an ASCII hex character stream and writes the decoded words into the system memory through its write port. It is used to preload program images in hardware and in simulation. The CPU is held off until loading completes. It sits between a character source (UART receiver or testbench driver) and the `mem` write port. It generalises hex-image loading in three ways: parametrised data/address width, `@address` relocation records, and explicit error reporting.

## Interface
- `ADDR_WIDTH`, 16, memory address width; must be a multiple of 4.
- `DATA_WIDTH`, 8, memory word width; must be a multiple of 4.
- `BASE_ADDR`, 0, load address used after `start` until the first `@` record.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  one-cycle pulse; begins a load. Ignored while `busy`.
- `char_valid`  in  1  `char_in` is valid.
- `char_in`  in  8  ASCII character.
- `char_ready`  out  1  loader accepts the character this cycle.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_addr`  out  ADDR_WIDTH  write address.
- `mem_din`  out  DATA_WIDTH  write data.
- `busy`  out  1  load in progress.
- `done`  out  1  load finished cleanly; held until next `start`.
- `error`  out  1  load aborted; held until next `start`.
- `error_code`  out  2  0 none, 1 illegal char, 2 partial word, 3 address too long.
- `word_count`  out  ADDR_WIDTH+1  words written since `start`.
- `cpu_run`  out  1  equals `done`; gates CPU reset release.

## Operation
- Character classes:
  - hex digit `0-9 A-F a-f`
  - separator: space, tab, CR, LF
  - `@` starts an address record
  - `:` is treated as a separator
  - EOT (8'h04) ends the load
  - any other character is illegal.
- States: IDLE, DATA, ADDR, WRITE, DONE, ERROR.
- **IDLE.** `start` loads `addr <= BASE_ADDR`, clears the nibble count and `word_count`, and moves to DATA.
- **DATA.** Each hex digit shifts in: `word <= {word, nib}`.
  - When nibble count reaches DATA_WIDTH/4, go to WRITE.
  - Separator with 0 nibbles pending: stay.
  - Separator with a partial word: ERROR code 2.
  - `@` with 0 pending: clear address accumulator, go to ADDR. `@` with a partial word: ERROR code 2.
  - EOT with 0 pending: DONE. EOT with a partial word: ERROR code 2.
  - Illegal character: ERROR code 1.
- **ADDR.** Hex digits shift into the address accumulator.
  - More than ADDR_WIDTH/4 digits: ERROR code 3.
  - Separator or EOT with ≥1 digit: `addr <= accumulator`. Separator returns to DATA; EOT goes to DONE.
  - Separator or EOT with 0 digits: ERROR code 1.
  - Any other character, including `@`: ERROR code 1.
- **WRITE.**
  - Drives `mem_we=1`, `mem_addr=addr`, `mem_din=word`.
  - Next state: `addr <= addr+1`, which wraps modulo 2^ADDR_WIDTH with no error; `word_count++`, which saturates at all-ones.
  - Returns to DATA.
- **DONE / ERROR.** Both states are held. `start` re-enters the IDLE actions and goes to DATA in one step.
- `busy` is 1 in DATA, ADDR, WRITE.
- `char_ready` is 1 in DATA and ADDR only.
- `start` asserted while `busy` is ignored.

## Timing
- Reset values:
  - state IDLE
  - `char_ready=0`, `mem_we=0`, `busy=0`, `done=0`, `error=0`
  - `error_code=0`, `word_count=0`, `cpu_run=0`
  - `mem_addr=BASE_ADDR`, `mem_din=0`.
- Reset mid-load aborts immediately (asynchronous). `mem_we` drops without waiting for a clock. No partial write completes.
- A character is consumed on a rising edge with `char_valid && char_ready`.
- Latency: the final nibble of a word is accepted at edge N.
  - WRITE state (`mem_we=1`) is visible during cycle N+1.
  - `char_ready` is 0 during that cycle.
  - The next character can be accepted at edge N+2.
- `mem_addr` and `mem_din` are registered and stable throughout the `mem_we` cycle. The memory samples on its clock edge.
- `done`, `error`, `error_code` and `cpu_run` update on the edge after the terminating character. `error_code` holds its value until `start`.
- `start` and `char_valid` in the same cycle while in IDLE/DONE/ERROR: `start` wins; the character is not consumed (`char_ready=0` that cycle).

## Structure
- Package `PKG/pkg.v` holds:
  - the state enum `loader_state_t`
  - the error-code enum `loader_err_t`
  - character constants `CHAR_EOT`, `CHAR_AT`, `CHAR_COLON`, `CHAR_SP`, `CHAR_CR`, `CHAR_LF`, `CHAR_TAB`.
- Sub-module `hex_char_decode`, combinational:
  - in: `char_in`
  - out: `is_hex`, `nib[3:0]`, `is_sep`, `is_at`, `is_eot`
  - It replaces ad-hoc nibble conversion everywhere; the testbench may reuse it.
- The top module holds the FSM, the address and word accumulators, and the counters.

## Test plan
- DATA_WIDTH=8, BASE_ADDR=16'h0200, stream `"A9 01 8D"`+EOT -> writes 0200=A9, 0201=01, 0202=8D; `word_count=3`, `done=1`, `cpu_run=1`.
- Stream `"@FFFE 11 22 33"`+EOT -> writes FFFE=11, FFFF=22, 0000=33 (wrap); `done=1`, `error=0`.
- Stream `"A9 0"`+EOT -> one write (0200=A9), then `error=1`, `error_code=2`, `done=0`.
- Stream `"@12345"` -> `error_code=3` after the 5th digit; no write; `char_ready=0` afterwards. Stream `"A9 G"` -> `error_code=1` after one write.
- DATA_WIDTH=16, stream `"beef CAFE"`+EOT -> 0200=BEEF, 0201=CAFE; `char_valid` held high throughout -> `char_ready` low exactly in each WRITE cycle.
- `reset_n` low at the WRITE cycle of the second word -> `mem_we` drops immediately and all outputs reach reset values. `start` then reloads from `BASE_ADDR` with `word_count=0`.
